// File: rtl/sc_fifo_af_ae_pkg.sv
// Shared defaults and flag bundle for the interpolator sample FIFO.
// The flag struct keeps the four status bits together as one registered word.
package sc_fifo_af_ae_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 3;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/sc_fifo_af_ae_if.sv
// Handshake, threshold and status bundle between a sample producer/consumer and the FIFO.
// The master side drives requests and margins; the slave side is the FIFO itself.
interface sc_fifo_af_ae_if
    import sc_fifo_af_ae_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                  Write_enable_i;
    logic                  Read_enable__i;
    logic [ADDR_WIDTH-1:0] differenceAF_i;
    logic [ADDR_WIDTH-1:0] differenceAE_i;
    logic [DATA_WIDTH-1:0] data_input___i;
    logic [DATA_WIDTH-1:0] data_output__o;
    logic                  Empty_Indica_o;
    logic                  Full_Indicat_o;
    logic                  Almost_Full__o;
    logic                  Almost_Empty_o;

    modport master (
        output Write_enable_i,
        output Read_enable__i,
        output differenceAF_i,
        output differenceAE_i,
        output data_input___i,
        input  data_output__o,
        input  Empty_Indica_o,
        input  Full_Indicat_o,
        input  Almost_Full__o,
        input  Almost_Empty_o
    );

    modport slave (
        input  Write_enable_i,
        input  Read_enable__i,
        input  differenceAF_i,
        input  differenceAE_i,
        input  data_input___i,
        output data_output__o,
        output Empty_Indica_o,
        output Full_Indicat_o,
        output Almost_Full__o,
        output Almost_Empty_o
    );

endinterface

// File: rtl/sc_fifo_af_ae_ram.sv
// Simple dual-port RAM: synchronous write, registered read with a resettable output register.
// The storage array itself is never reset so it can map onto block RAM.
module fifo_dp_ram
    import sc_fifo_af_ae_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output holds its last value whenever no read is taken.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sc_fifo_af_ae.sv
// Single-clock FIFO with full/empty and run-time programmable almost-full/almost-empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module sc_fifo_af_ae
    import sc_fifo_af_ae_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_async_la_i,
    sc_fifo_af_ae_if.slave      bus
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH:0] rd_ptr_d, rd_ptr_q;
    logic [ADDR_WIDTH:0] count_d;
    logic [ADDR_WIDTH:0] af_thresh;
    fifo_flags_t         flags_d, flags_q;
    logic                wr_ok;
    logic                rd_ok;

    // Requests are qualified against the registered flags, independently of each other.
    assign wr_ok = bus.Write_enable_i & ~flags_q.full;
    assign rd_ok = bus.Read_enable__i & ~flags_q.empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Flags come from the next-state occupancy so they line up with the pointers after the edge.
    always_comb begin
        count_d   = wr_ptr_d - rd_ptr_d;
        af_thresh = DEPTH_P - {1'b0, bus.differenceAF_i};
        flags_d   = FLAGS_RESET;
        flags_d.empty        = (count_d == '0);
        flags_d.full         = (count_d == DEPTH_P);
        flags_d.almost_full  = (count_d >= af_thresh);
        flags_d.almost_empty = (count_d <= {1'b0, bus.differenceAE_i});
    end

    always_ff @(posedge clk or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            flags_q  <= FLAGS_RESET;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
        end
    end

    fifo_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_async_la_i),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (bus.data_input___i),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (bus.data_output__o)
    );

    assign bus.Empty_Indica_o = flags_q.empty;
    assign bus.Full_Indicat_o = flags_q.full;
    assign bus.Almost_Full__o = flags_q.almost_full;
    assign bus.Almost_Empty_o = flags_q.almost_empty;

endmodule

// File: tb/tb_sc_fifo_af_ae.sv
// Directed bench for sc_fifo_af_ae: a queue scoreboard predicts read data, an occupancy model predicts flags.
module tb_sc_fifo_af_ae;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int cnt_m;
    int af_m;
    int ae_m;
    logic [DW-1:0] last_dout;
    logic [DW-1:0] exp_q [$];

    sc_fifo_af_ae_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo_if ();

    sc_fifo_af_ae #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst_async_la_i (rst_n),
        .bus            (fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {empty, full, almost_full, almost_empty} expected for the model occupancy.
    function automatic logic [31:0] exp_flags();
        logic [3:0] f;
        f[3] = (cnt_m == 0);
        f[2] = (cnt_m == DEPTH);
        f[1] = (cnt_m >= DEPTH - af_m);
        f[0] = (cnt_m <= ae_m);
        return {28'd0, f};
    endfunction

    function automatic logic [31:0] dut_flags();
        return {28'd0, fifo_if.Empty_Indica_o, fifo_if.Full_Indicat_o,
                fifo_if.Almost_Full__o, fifo_if.Almost_Empty_o};
    endfunction

    task automatic set_margins(input int af, input int ae);
        @(negedge clk);
        af_m = af;
        ae_m = ae;
        fifo_if.differenceAF_i = AW'(af);
        fifo_if.differenceAE_i = AW'(ae);
    endtask

    task automatic step(input logic we, input logic re, input logic [DW-1:0] din);
        logic wr_ok;
        logic rd_ok;
        @(negedge clk);
        fifo_if.Write_enable_i = we;
        fifo_if.Read_enable__i = re;
        fifo_if.data_input___i = din;
        wr_ok = we && (cnt_m != DEPTH);
        rd_ok = re && (cnt_m != 0);
        @(posedge clk);
        #1;
        fifo_if.Write_enable_i = 1'b0;
        fifo_if.Read_enable__i = 1'b0;
        if (rd_ok) begin
            last_dout = exp_q.pop_front();
            cnt_m--;
        end
        if (wr_ok) begin
            exp_q.push_back(din);
            cnt_m++;
        end
        check("dout", fifo_if.data_output__o, last_dout);
        check("flags", dut_flags(), exp_flags());
        $display("txn we=%0b re=%0b din=%h dout=%h count=%0d flags=%b",
                 we, re, din, fifo_if.data_output__o, cnt_m, dut_flags()[3:0]);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cnt_m     = 0;
        last_dout = '0;
        af_m      = 2;
        ae_m      = 2;
        rst_n     = 1'b0;
        fifo_if.Write_enable_i = 1'b0;
        fifo_if.Read_enable__i = 1'b0;
        fifo_if.data_input___i = '0;
        fifo_if.differenceAF_i = 3'd2;
        fifo_if.differenceAE_i = 3'd2;

        // 1: reset state, then idle
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", dut_flags(), 32'h9);
        check("reset_dout", fifo_if.data_output__o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0);

        // 2: fill to full, then a dropped write
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DW'(i * 32'h11));
        step(1'b1, 1'b0, 32'h99);

        // 3: drain in order, then a read while empty
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        check("drain_last", fifo_if.data_output__o, 32'h88);
        step(1'b0, 1'b1, '0);

        // 4: wrap-around
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(32'h100 + r * 16 + i));
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
        end

        // 5: simultaneous read+write at 4, 0 and 8
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(32'hA0 + i));
        step(1'b1, 1'b1, 32'hB0);
        step(1'b1, 1'b1, 32'hB1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 32'hC0);
        step(1'b0, 1'b1, '0);
        set_margins(0, 0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(32'hD0 + i));
        step(1'b1, 1'b1, 32'hE0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, '0);
        set_margins(2, 2);

        // 6: asynchronous reset mid-stream at count 5
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(32'hF0 + i));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_flags", dut_flags(), 32'h9);
        check("async_rst_dout", fifo_if.data_output__o, 32'h0);
        exp_q.delete();
        cnt_m     = 0;
        last_dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'hABCD);
        step(1'b0, 1'b1, '0);
        check("post_rst_data", fifo_if.data_output__o, 32'hABCD);
        step(1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
